// File: rtl/dac_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dac_frame_ctrl_pkg
// Shared definitions for the DAC frame controller:
//   - frame_state_e : FSM state encoding (IDLE, SHIFT, LATCH, GAP)
//   - legal limits for the CLKDIV and GAP_CYC parameters
//   - clamp_range   : folds an out-of-range parameter back into its legal span
// -----------------------------------------------------------------------------
package dac_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_GAP   = 2'd3
    } frame_state_e;

    localparam int CLKDIV_MIN  = 1;
    localparam int CLKDIV_MAX  = 255;
    localparam int GAP_CYC_MIN = 0;
    localparam int GAP_CYC_MAX = 255;

    // Both the dclk phase divider and the gap counter are 8 bits wide.
    localparam int DIV_CNT_W = 8;

    // Clamp a parameter value into [lo, hi] so an illegal setting cannot
    // produce a zero-length phase or an overflowing counter compare.
    function automatic int clamp_range(input int value, input int lo, input int hi);
        if (value < lo) begin
            return lo;
        end else if (value > hi) begin
            return hi;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/dac_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// dac_frame_ctrl_if
// Sample-stream handshake, DAC serial pins and status flags of the frame
// controller, bundled as one interface.
//   slave  : the controller's view (takes samples, drives the DAC pins)
//   master : the producer/supervisor's view
// Signals:
//   en, s_valid, s_data, clr_underrun           -> into the controller
//   s_ready, dclk, dce_n, dout, busy,
//   frame_done, underrun                        <- out of the controller
// -----------------------------------------------------------------------------
interface dac_frame_ctrl_if #(
    parameter int DWIDTH = 8
);
    logic              en;
    logic              s_valid;
    logic [DWIDTH-1:0] s_data;
    logic              s_ready;
    logic              dclk;
    logic              dce_n;
    logic              dout;
    logic              busy;
    logic              frame_done;
    logic              underrun;
    logic              clr_underrun;

    modport slave (
        input  en, s_valid, s_data, clr_underrun,
        output s_ready, dclk, dce_n, dout, busy, frame_done, underrun
    );

    modport master (
        output en, s_valid, s_data, clr_underrun,
        input  s_ready, dclk, dce_n, dout, busy, frame_done, underrun
    );
endinterface

// File: rtl/dac_frame_ctrl_clkdiv.sv
// -----------------------------------------------------------------------------
// dac_clkdiv
// dclk phase divider. Counts CLKDIV clk10m cycles per phase and toggles the
// phase bit at the end of each phase, so phase is directly usable as a
// registered, glitch-free dclk.
// Ports:
//   clk10m, rst_n : clock, synchronous active-low reset
//   clr           : restart at count 0, phase 0 (takes priority over counting)
//   phase         : 0 = low half, 1 = high half of the dclk period
//   phase_end     : last cycle of the current phase
//   period_end    : last cycle of the high phase (one full dclk period done)
// -----------------------------------------------------------------------------
module dac_clkdiv
    import dac_frame_ctrl_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic clk10m,
    input  logic rst_n,
    input  logic clr,
    output logic phase,
    output logic phase_end,
    output logic period_end
);

    localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(CLKDIV - 1);

    logic [DIV_CNT_W-1:0] cnt_r;
    logic                 phase_r;

    // Phase counter and phase bit.
    always_ff @(posedge clk10m) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (clr) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r   <= '0;
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + DIV_CNT_W'(1);
        end
    end

    assign phase      = phase_r;
    assign phase_end  = (cnt_r == LAST_CNT);
    assign period_end = (cnt_r == LAST_CNT) & phase_r;

endmodule

// File: rtl/dac_frame_ctrl.sv
// -----------------------------------------------------------------------------
// dac_frame_ctrl
// Takes one DWIDTH-bit sample per frame over a valid/ready handshake and
// shifts it LSB first to a serial DAC: DWIDTH dclk periods of data, a
// CLKDIV-cycle active-low latch strobe, then GAP_CYC idle cycles.
// Ports:
//   clk10m : sole clock
//   rst_n  : synchronous active-low reset; abandons any frame in progress
//   bus    : dac_frame_ctrl_if.slave -- en, s_valid/s_data/s_ready handshake,
//            dclk/dce_n/dout DAC pins, busy, frame_done, underrun,
//            clr_underrun
// Frame length from handshake to the next s_ready is
// 2*CLKDIV*DWIDTH + CLKDIV + GAP_CYC cycles; frame_done marks its last cycle.
// -----------------------------------------------------------------------------
module dac_frame_ctrl
    import dac_frame_ctrl_pkg::*;
#(
    parameter int DWIDTH  = 8,
    parameter int CLKDIV  = 4,
    parameter int GAP_CYC = 2
) (
    input  logic           clk10m,
    input  logic           rst_n,
    dac_frame_ctrl_if.slave bus
);

    localparam int CLKDIV_EFF  = clamp_range(CLKDIV,  CLKDIV_MIN,  CLKDIV_MAX);
    localparam int GAP_CYC_EFF = clamp_range(GAP_CYC, GAP_CYC_MIN, GAP_CYC_MAX);
    localparam int BIT_W       = $clog2(DWIDTH + 1);

    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(DWIDTH - 1);
    localparam logic [DIV_CNT_W-1:0] GAP_LAST = (GAP_CYC_EFF > 0) ?
                                                DIV_CNT_W'(GAP_CYC_EFF - 1) :
                                                DIV_CNT_W'(0);

    frame_state_e         state_r;
    frame_state_e         state_nx_s;
    logic [DWIDTH-1:0]    shreg_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [DIV_CNT_W-1:0] gap_cnt_r;
    logic                 dce_n_r;
    logic                 busy_r;
    logic                 underrun_r;
    logic                 armed_r;

    logic                 div_clr_s;
    logic                 div_phase_s;
    logic                 div_phase_end_s;
    logic                 div_period_end_s;

    logic                 s_ready_s;
    logic                 hs_s;
    logic                 last_bit_s;
    logic                 latch_end_s;
    logic                 gap_end_s;
    logic                 frame_done_s;
    logic                 underrun_set_s;

    dac_clkdiv #(
        .CLKDIV (CLKDIV_EFF)
    ) u_clkdiv (
        .clk10m     (clk10m),
        .rst_n      (rst_n),
        .clr        (div_clr_s),
        .phase      (div_phase_s),
        .phase_end  (div_phase_end_s),
        .period_end (div_period_end_s)
    );

    // Handshake, end-of-state strobes and underrun set condition.
    always_comb begin
        s_ready_s      = (state_r == ST_IDLE) & bus.en;
        hs_s           = s_ready_s & bus.s_valid;
        last_bit_s     = (state_r == ST_SHIFT) & div_period_end_s & (bit_cnt_r == LAST_BIT);
        latch_end_s    = (state_r == ST_LATCH) & div_phase_end_s;
        gap_end_s      = (state_r == ST_GAP) & (gap_cnt_r == GAP_LAST);
        underrun_set_s = (state_r == ST_IDLE) & bus.en & ~bus.s_valid & armed_r;
        if (GAP_CYC_EFF == 0) begin
            frame_done_s = latch_end_s;
        end else begin
            frame_done_s = gap_end_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_nx_s = ST_LATCH;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_LATCH: begin
                if (latch_end_s) begin
                    state_nx_s = (GAP_CYC_EFF == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    state_nx_s = ST_LATCH;
                end
            end
            ST_GAP: begin
                if (gap_end_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_GAP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // The divider only runs inside SHIFT and LATCH, and restarts on every
    // state change, so its phase bit is 0 everywhere except the high half of
    // each SHIFT bit and can drive dclk directly.
    always_comb begin
        if ((state_nx_s != state_r) ||
            ((state_r != ST_SHIFT) && (state_r != ST_LATCH))) begin
            div_clr_s = 1'b1;
        end else begin
            div_clr_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk10m) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Shift register, bit counter and gap counter.
    // The register shifts in zeros, so after DWIDTH shifts it is all-zero and
    // shreg_r[0] is already the required dout=0 in LATCH, GAP and IDLE.
    always_ff @(posedge clk10m) begin
        if (!rst_n) begin
            shreg_r   <= '0;
            bit_cnt_r <= '0;
            gap_cnt_r <= '0;
        end else begin
            if (hs_s) begin
                shreg_r   <= bus.s_data;
                bit_cnt_r <= '0;
            end else if ((state_r == ST_SHIFT) && div_period_end_s) begin
                shreg_r   <= shreg_r >> 1;
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end
            if ((state_r == ST_GAP) && !gap_end_s) begin
                gap_cnt_r <= gap_cnt_r + DIV_CNT_W'(1);
            end else begin
                gap_cnt_r <= '0;
            end
        end
    end

    // Registered latch strobe and busy flag, decoded from the next state.
    always_ff @(posedge clk10m) begin
        if (!rst_n) begin
            dce_n_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            dce_n_r <= (state_nx_s != ST_LATCH);
            busy_r  <= (state_nx_s != ST_IDLE);
        end
    end

    // Sticky underrun; only armed once a frame has completed since reset.
    always_ff @(posedge clk10m) begin
        if (!rst_n) begin
            underrun_r <= 1'b0;
            armed_r    <= 1'b0;
        end else begin
            if (frame_done_s) begin
                armed_r <= 1'b1;
            end
            if (underrun_set_s) begin
                underrun_r <= 1'b1;
            end else if (bus.clr_underrun) begin
                underrun_r <= 1'b0;
            end
        end
    end

    assign bus.s_ready    = s_ready_s;
    assign bus.dclk       = div_phase_s;
    assign bus.dout       = shreg_r[0];
    assign bus.dce_n      = dce_n_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_s;
    assign bus.underrun   = underrun_r;

endmodule
